// File: rtl/fetch_pc_ctrl_if.sv
// Pipeline-side bundle for the fetch PC controller: decoder prediction hints,
// execute-stage resolution, and the fetch PC / squash / statistics outputs.
interface fetch_pc_ctrl_if;
  logic        stall;
  logic        pred_is_jal;
  logic        pred_is_branch;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic        ex_mispredict;
  logic [31:0] ex_correct_pc;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        squash;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output stall, pred_is_jal, pred_is_branch, pred_target,
           ex_valid, ex_is_branch, ex_taken, ex_pc, ex_mispredict, ex_correct_pc,
    input  pc, fetch_valid, squash, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  stall, pred_is_jal, pred_is_branch, pred_target,
           ex_valid, ex_is_branch, ex_taken, ex_pc, ex_mispredict, ex_correct_pc,
    output pc, fetch_valid, squash, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: boot, sequential/predicted fetch with a 2-bit BHT,
// stall hold, and execute-stage redirect with a timed squash window.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BHT_IDX_W    = 6,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  localparam int         BHT_N        = 1 << BHT_IDX_W;
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         FLUSH_ONE    = (FLUSH_CYCLES == 1);

  state_e         state_q;
  logic [31:0]    pc_q, pc_d;
  logic           fetch_valid_q;
  logic [2:0]     flush_cnt_q;
  logic [31:0]    branch_cnt_q, mispredict_cnt_q;
  logic [1:0]     bht_q [BHT_N];

  logic                 redirect, bht_we, predict_taken;
  logic [BHT_IDX_W-1:0] fetch_idx, ex_idx;
  logic                 unused_bits;

  assign redirect      = ctrl.ex_valid & ctrl.ex_mispredict;
  assign bht_we        = ctrl.ex_valid & ctrl.ex_is_branch;
  assign fetch_idx     = pc_q[BHT_IDX_W+1:2];
  assign ex_idx        = ctrl.ex_pc[BHT_IDX_W+1:2];
  assign predict_taken = ctrl.pred_is_branch & bht_q[fetch_idx][1];
  assign unused_bits   = ^{ctrl.ex_pc[31:BHT_IDX_W+2], ctrl.ex_pc[1:0],
                           ctrl.ex_correct_pc[1:0], ctrl.pred_target[1:0]};

  // Next-PC priority: redirect, then (only while running) stall, JAL, predicted branch, sequential.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {ctrl.ex_correct_pc[31:2], 2'b00};
    end else if (state_q == RUN) begin
      if (ctrl.stall) begin
        pc_d = pc_q;
      end else if (ctrl.pred_is_jal || predict_taken) begin
        pc_d = {ctrl.pred_target[31:2], 2'b00};
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= BOOT;
      pc_q             <= RESET_PC;
      fetch_valid_q    <= 1'b0;
      flush_cnt_q      <= 3'd0;
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;

      // Branch training runs regardless of fetch state; reads above still see the old entry.
      if (bht_we) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
        if (ctrl.ex_taken && (bht_q[ex_idx] != 2'b11)) begin
          bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
        end else if (!ctrl.ex_taken && (bht_q[ex_idx] != 2'b00)) begin
          bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
        end
      end

      if (redirect) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        flush_cnt_q      <= FLUSH_RELOAD;
        if (FLUSH_ONE) begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end else begin
          state_q       <= FLUSH;
          fetch_valid_q <= 1'b0;
        end
      end else begin
        case (state_q)
          BOOT: begin
            state_q       <= RUN;
            fetch_valid_q <= 1'b1;
          end
          RUN: begin
            fetch_valid_q <= 1'b1;
          end
          FLUSH: begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
            if (flush_cnt_q <= 3'd1) begin
              state_q       <= RUN;
              fetch_valid_q <= 1'b1;
            end else begin
              fetch_valid_q <= 1'b0;
            end
          end
          default: begin
            state_q       <= BOOT;
            fetch_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctrl.pc             = pc_q;
  assign ctrl.fetch_valid    = fetch_valid_q;
  assign ctrl.squash         = (state_q == FLUSH) | redirect;
  assign ctrl.branch_cnt     = branch_cnt_q;
  assign ctrl.mispredict_cnt = mispredict_cnt_q;

endmodule
